// File: rtl/gouram_trace_pkg.sv
// Shared trace types for the pipeline-stage trackers and the trace arbiter.
package gouram_trace_pkg;

    typedef int trace_output_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trace_src_fifo.sv
// Per-source trace FIFO: no backpressure toward the tracker, so a push into a
// full FIFO without a simultaneous pop is reported on drop.
module trace_src_fifo
    import gouram_trace_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = trace_output_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head_data,
    output logic empty,
    output logic full,
    output logic drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    rec_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin merge of per-tracker trace FIFOs into one registered valid/ready
// stream. Optional per-source drop counters under TRACE_ARB_DROP_COUNT_EN.
module trace_arbiter
    import gouram_trace_pkg::*;
#(
    parameter int  NUM_SRC      = 2,
    parameter int  DEPTH        = 4,
    parameter type trace_output = trace_output_t,
    localparam int SRC_W        = src_w(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  trace_output              src_data [NUM_SRC],
    output logic                     out_valid,
    input  logic                     out_ready,
    output trace_output              out_data,
    output logic [SRC_W-1:0]         out_src,
`ifdef TRACE_ARB_DROP_COUNT_EN
    output logic [NUM_SRC-1:0][15:0] drop_count,
`endif
    output logic [NUM_SRC-1:0]       overflow
);

    arb_state_e        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    trace_output       out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [SRC_W-1:0]  last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0] overflow_q;

    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_drop;
    logic [NUM_SRC-1:0] fifo_pop;
    trace_output        fifo_head [NUM_SRC];

    logic              load;
    logic              load_en;
    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        trace_src_fifo #(
            .DEPTH (DEPTH),
            .rec_t (trace_output)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (src_valid[i]),
            .push_data (src_data[i]),
            .pop       (fifo_pop[i]),
            .head_data (fifo_head[i]),
            .empty     (fifo_empty[i]),
            .full      (fifo_full[i]),
            .drop      (fifo_drop[i])
        );
        assign fifo_pop[i] = load_en && (grant_idx == SRC_W'(i));
    end

    // Scan starts one past the last winner, so every source gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!grant_found && !fifo_empty[(int'(last_grant_q) + k) % NUM_SRC]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'((int'(last_grant_q) + k) % NUM_SRC);
            end
        end
    end

    assign load    = (state_q == ARB_IDLE) || (out_valid_q && out_ready);
    assign load_en = load && grant_found;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            state_d      = ARB_HOLD;
            out_valid_d  = 1'b1;
            out_data_d   = fifo_head[grant_idx];
            out_src_d    = grant_idx;
            last_grant_d = grant_idx;
        end else if (load) begin
            state_d     = ARB_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            overflow_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_q | fifo_drop;
        end
    end

`ifdef TRACE_ARB_DROP_COUNT_EN
    logic [NUM_SRC-1:0][15:0] drop_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fifo_drop[i] && (drop_count_q[i] != 16'hFFFF)) begin
                    drop_count_q[i] <= drop_count_q[i] + 16'd1;
                end
            end
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: queue-based reference model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_trace_arbiter;

    localparam int NSRC  = 2;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [NSRC-1:0]  src_valid;
    int               src_data [NSRC];
    logic             out_valid;
    logic             out_ready;
    int               out_data;
    logic [0:0]       out_src;
    logic [NSRC-1:0]  overflow;
`ifdef TRACE_ARB_DROP_COUNT_EN
    logic [NSRC-1:0][15:0] drop_count;
`endif

    trace_arbiter #(
        .NUM_SRC (NSRC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_data  (src_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef TRACE_ARB_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue per source, the output register, and the last winner.
    int  mq [NSRC][$];
    bit  m_ov;
    int  m_data;
    int  m_src;
    int  m_last;
    bit  m_ovf [NSRC];
    int  m_dc  [NSRC];

    task automatic m_reset();
        for (int s = 0; s < NSRC; s++) begin
            mq[s].delete();
            m_ovf[s] = 1'b0;
            m_dc[s]  = 0;
        end
        m_ov   = 1'b0;
        m_data = 0;
        m_src  = 0;
        m_last = NSRC - 1;
    endtask

    task automatic m_step();
        bit hs, ld, found;
        hs = m_ov && out_ready;
        ld = !m_ov || hs;
        if (ld) begin
            found = 1'b0;
            for (int k = 1; k <= NSRC; k++) begin
                int s;
                s = (m_last + k) % NSRC;
                if (!found && mq[s].size() > 0) begin
                    found  = 1'b1;
                    m_data = mq[s].pop_front();
                    m_src  = s;
                    m_last = s;
                end
            end
            m_ov = found;
        end
        for (int s = 0; s < NSRC; s++) begin
            if (src_valid[s]) begin
                if (mq[s].size() < DEPTH) mq[s].push_back(src_data[s]);
                else begin
                    m_ovf[s] = 1'b1;
                    if (m_dc[s] < 16'hFFFF) m_dc[s]++;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_out_valid", out_valid, m_ov);
                if (m_ov) begin
                    check("cyc_out_data", out_data, m_data);
                    check("cyc_out_src", out_src, m_src);
                end
                for (int s = 0; s < NSRC; s++) begin
                    check("cyc_overflow", overflow[s], m_ovf[s]);
`ifdef TRACE_ARB_DROP_COUNT_EN
                    check("cyc_drop_count", drop_count[s], m_dc[s]);
`endif
                end
            end
        end
    end

    task automatic drive(input bit v0, input int d0, input bit v1, input int d1, input bit rdy);
        src_valid[0] = v0;
        src_data[0]  = d0;
        src_valid[1] = v1;
        src_data[1]  = d1;
        out_ready    = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1);
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1);
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        // Simultaneous sources: source 0 wins first after reset.
        drive(1, 32'hB0, 1, 32'hB1, 1);
        step();
        drive(0, 0, 0, 0, 1);
        check("sim_lat_valid", out_valid, 0);
        step();
        check("sim_first_valid", out_valid, 1);
        check("sim_first_data", out_data, 32'hB0);
        check("sim_first_src", out_src, 0);
        step();
        check("sim_second_data", out_data, 32'hB1);
        check("sim_second_src", out_src, 1);
        step();
        check("sim_idle_valid", out_valid, 0);

        // Single record.
        drive(1, 32'hA, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        check("single_e0_valid", out_valid, 0);
        step();
        check("single_e1_valid", out_valid, 1);
        check("single_e1_data", out_data, 32'hA);
        check("single_e1_src", out_src, 0);
        step();
        check("single_e2_valid", out_valid, 0);

        // Backpressure: six pulses, R6 dropped.
        for (int n = 1; n <= 6; n++) begin
            drive(1, 32'h100 + n, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        check("bp_overflow0", overflow[0], 1);
        check("bp_overflow1", overflow[1], 0);
        check("bp_hold_data", out_data, 32'h101);
`ifdef TRACE_ARB_DROP_COUNT_EN
        check("bp_drop_count0", drop_count[0], 1);
`endif
        step();
        check("bp_stall_data", out_data, 32'h101);
        drive(0, 0, 0, 0, 1);
        for (int n = 2; n <= 5; n++) begin
            step();
            check("bp_drain_data", out_data, 32'h100 + n);
        end
        step();
        check("bp_drain_done", out_valid, 0);

        // Full FIFO boundary: push and pop on the same edge.
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            drive(1, 32'h300 + n, 0, 0, 0);
            step();
        end
        drive(1, 32'h306, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        check("full_pushpop_ovf", overflow[0], 0);
        check("full_pushpop_data", out_data, 32'h302);
        for (int n = 3; n <= 6; n++) begin
            step();
            check("full_drain_data", out_data, 32'h300 + n);
        end
        step();
        check("full_drain_done", out_valid, 0);

        // Fairness: both sources every cycle.
        do_reset();
        for (int n = 0; n < 6; n++) begin
            drive(1, 32'h400 + n, 1, 32'h500 + n, 1);
            step();
            if (n >= 1) check("fair_src", out_src, (n % 2 == 1) ? 0 : 1);
        end
        check("fair_no_drop", overflow, 0);
        drive(0, 0, 0, 0, 0);
        step();

        // Reset mid-stream while output is valid and FIFOs hold data.
        check("mid_pre_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", out_valid, 0);
        check("mid_async_ovf", overflow, 0);
        drive(0, 0, 0, 0, 1);
        repeat (2) step();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check("mid_no_stale", out_valid, 0);
        end

        // Traffic after reset still flows.
        drive(0, 0, 1, 32'h601, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        check("post_rst_data", out_data, 32'h601);
        check("post_rst_src", out_src, 1);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Merges trace records from several independent pipeline-stage trackers (IF tracker, EX/mem tracker, ...) into one trace stream toward the trace buffer/host link.
- Each tracker emits single-cycle valid pulses with no backpressure, so every source gets a small per-source FIFO.
- A round-robin scheduler drains the FIFOs into one registered valid/ready output.

Parameters:
- NUM_SRC, 2, number of tracker sources; at least 1.
- DEPTH, 4, per-source FIFO entries; power of 2, at least 2.
- trace_output, int, record type (type parameter), shared with the trackers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source one-cycle record strobe.
- src_data  in  NUM_SRC x trace_output  per-source record, sampled when src_valid[i]=1.
- out_valid  out  1  merged record available.
- out_ready  in  1  consumer accepts the record (handshake when out_valid and out_ready are both 1).
- out_data  out  trace_output  merged record.
- out_src  out  SRC_W  source index of out_data; SRC_W = max(1, $clog2(NUM_SRC)).
- overflow  out  NUM_SRC  sticky per-source drop flag.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; out_valid=0, out_data='0, out_src=0, overflow=0; last_grant=NUM_SRC-1, so source 0 wins first; state=IDLE.
- FIFOs:
  - Push when src_valid[i]=1 and FIFO i is not full.
  - Push into a full FIFO with no pop that cycle: record dropped, overflow[i] set; overflow clears only on reset.
  - Push and pop in the same cycle on a full FIFO: both succeed, no drop.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and LSBs equal.
  - FIFO order within a source is strictly preserved.
- Load condition: "load" happens when (state==IDLE) or (out_valid and out_ready).
- Scheduler FSM:
  - IDLE: out_valid=0. If any FIFO is non-empty, load, then go to HOLD.
  - HOLD: out_valid=1; out_data and out_src are held stable while out_ready=0. On handshake: if any FIFO is non-empty, load the next record and stay in HOLD; otherwise out_valid goes to 0 and the FSM returns to IDLE.
- Load: grant the first non-empty source scanning last_grant+1, last_grant+2, ... modulo NUM_SRC. Pop its FIFO head into out_data, set out_src = grant, set last_grant = grant.
- Grant decision uses FIFO occupancy registered before the edge, so a record pushed at edge k is never granted at edge k.
- Latency: src_valid sampled at edge k -> out_valid visible after edge k+1 (FSM idle, FIFO previously empty).
- Throughput: one record per cycle while out_ready=1 and data is pending.
- Storage under backpressure: at most DEPTH records per source buffered, plus the single output register.

Optional Feature:
- Macro TRACE_ARB_DROP_COUNT_EN.
- With the macro: extra output drop_count, NUM_SRC x 16 bits, one counter per source. A counter increments on each dropped record, saturates at 16'hFFFF, and resets to 0.
- Without the macro: the port and counters do not exist; overflow flags only.

Decomposition:
- Shared package gouram_trace_pkg holds:
  - the trace_output record typedef, used by the trackers and this block;
  - the SRC_W helper function;
  - the IDLE/HOLD state enum.
- One sub-module, trace_src_fifo:
  - parameters DEPTH and record type;
  - ports push, push_data, pop, head_data, empty, full, drop;
  - instantiated NUM_SRC times via generate.

Test Plan:
- Single record: src_valid[0] pulse with data A at edge 0, out_ready=1 -> out_valid=1, out_data=A, out_src=0 after edge 1; out_valid=0 after edge 2.
- Simultaneous sources: src0=A and src1=B in the same cycle, ready=1 -> A/src0 then B/src1 on consecutive cycles.
- Backpressure: out_ready=0, six consecutive pulses on src0 (R1..R6), DEPTH=4 -> R6 dropped and overflow[0]=1 (drop_count[0]=1 with the macro); raise ready -> R1..R5 in order, out_data stable during the stall.
- Fairness: both sources pulse every cycle and ready=1 -> out_src alternates 0,1,0,1; no drops on either source.
- Full FIFO boundary: FIFO0 full, ready=1, a new push in the same cycle as a pop -> accepted, overflow[0] stays 0.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and FIFOs hold data -> out_valid=0 immediately (async); after release, no stale record is emitted and overflow=0.
